// File: rtl/multi_mode_counter.sv
// Multi-mode up/down counter with prescaler.
// Modes: 00 wrap, 01 saturate, 10 modulo-limit, 11 ping-pong between 0 and limit.
// Wrap, clamp and turn events give a one-cycle terminalCount pulse and set a sticky overflow flag.
module multi_mode_counter #(
  parameter int WIDTH  = 8,
  parameter int PWIDTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              direction,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  step,
  input  logic [PWIDTH-1:0] prescale,
  input  logic              clear,
  input  logic              load,
  input  logic              clearFlag,
  input  logic [WIDTH-1:0]  loadValue,
  output logic [WIDTH-1:0]  counterValue,
  output logic              terminalCount,
  output logic              overflow,
  output logic              countingUp
);

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SATURATE = 2'b01;
  localparam logic [1:0] MODE_MODULO   = 2'b10;
  localparam logic [1:0] MODE_PINGPONG = 2'b11;

  localparam logic [PWIDTH-1:0] PS_ONE = {{(PWIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  count_q, count_d;
  logic [PWIDTH-1:0] prescaler_q, prescaler_d;
  logic              tc_q, tc_d;
  logic              overflow_q, overflow_d;
  logic              ppUp_q, ppUp_d;

  logic              tick;
  logic              psWrap;
  logic              effUp;
  logic [WIDTH:0]    sumWide;
  logic [WIDTH:0]    diffWide;
  logic              carry;
  logic              borrow;
  logic              upCross;
  logic              upTurn;
  logic              downTurn;
  logic [WIDTH-1:0]  stepValue;
  logic              stepEvent;
  logic              stepNewUp;
  logic [WIDTH-1:0]  loadClamped;

  // Tick on the enabled cycle where the prescaler reaches prescale; psWrap also
  // covers a prescale lowered below the running count, which restarts without a tick.
  always_comb begin
    tick   = enable && (prescaler_q == prescale);
    psWrap = (prescaler_q >= prescale);
  end

  // Ping-pong uses its own remembered direction; other modes follow the input.
  always_comb begin
    effUp = (mode == MODE_PINGPONG) ? ppUp_q : direction;
  end

  // One extra bit on the sum and difference exposes carry and borrow.
  always_comb begin
    sumWide  = {1'b0, count_q} + {1'b0, step};
    diffWide = {1'b0, count_q} - {1'b0, step};
    carry    = sumWide[WIDTH];
    borrow   = diffWide[WIDTH];
    upCross  = (sumWide > {1'b0, limit});
    upTurn   = (sumWide >= {1'b0, limit});
    downTurn = borrow || (diffWide == '0);
  end

  // Value, event and ping-pong direction a tick would produce in the current mode.
  always_comb begin
    stepValue = count_q;
    stepEvent = 1'b0;
    stepNewUp = ppUp_q;
    if (step != '0) begin
      case (mode)
        MODE_WRAP: begin
          if (effUp) begin
            stepValue = sumWide[WIDTH-1:0];
            stepEvent = carry;
          end else begin
            stepValue = diffWide[WIDTH-1:0];
            stepEvent = borrow;
          end
        end
        MODE_SATURATE: begin
          if (effUp) begin
            stepValue = carry ? '1 : sumWide[WIDTH-1:0];
            stepEvent = carry;
          end else begin
            stepValue = borrow ? '0 : diffWide[WIDTH-1:0];
            stepEvent = borrow;
          end
        end
        MODE_MODULO: begin
          if (effUp) begin
            stepValue = upCross ? '0 : sumWide[WIDTH-1:0];
            stepEvent = upCross;
          end else begin
            stepValue = borrow ? limit : diffWide[WIDTH-1:0];
            stepEvent = borrow;
          end
        end
        default: begin
          if (effUp) begin
            if (upTurn) begin
              stepValue = limit;
              stepEvent = 1'b1;
              stepNewUp = 1'b0;
            end else begin
              stepValue = sumWide[WIDTH-1:0];
            end
          end else begin
            if (downTurn) begin
              stepValue = '0;
              stepEvent = 1'b1;
              stepNewUp = 1'b1;
            end else begin
              stepValue = diffWide[WIDTH-1:0];
            end
          end
        end
      endcase
    end
  end

  // Loaded values above limit are clamped in the limit-based modes.
  always_comb begin
    loadClamped = (mode[1] && (loadValue > limit)) ? limit : loadValue;
  end

  // Next state with clear over load over a counting tick; events beat clearFlag.
  always_comb begin
    count_d     = count_q;
    prescaler_d = prescaler_q;
    ppUp_d      = ppUp_q;
    tc_d        = 1'b0;
    overflow_d  = overflow_q;
    if (clear) begin
      count_d     = '0;
      prescaler_d = '0;
      ppUp_d      = 1'b1;
      overflow_d  = 1'b0;
    end else if (load) begin
      count_d     = loadClamped;
      prescaler_d = '0;
      ppUp_d      = direction;
      if (clearFlag) begin
        overflow_d = 1'b0;
      end
    end else begin
      if (enable) begin
        prescaler_d = psWrap ? '0 : prescaler_q + PS_ONE;
      end
      if (tick) begin
        count_d = stepValue;
        ppUp_d  = stepNewUp;
        tc_d    = stepEvent;
      end
      if (tick && stepEvent) begin
        overflow_d = 1'b1;
      end else if (clearFlag) begin
        overflow_d = 1'b0;
      end
    end
  end

  // State registers, forced to their idle values while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      prescaler_q <= '0;
      tc_q        <= 1'b0;
      overflow_q  <= 1'b0;
      ppUp_q      <= 1'b1;
    end else begin
      count_q     <= count_d;
      prescaler_q <= prescaler_d;
      tc_q        <= tc_d;
      overflow_q  <= overflow_d;
      ppUp_q      <= ppUp_d;
    end
  end

  // Output drive.
  always_comb begin
    counterValue  = count_q;
    terminalCount = tc_q;
    overflow      = overflow_q;
    countingUp    = effUp;
  end

endmodule

// File: tb/tb_multi_mode_counter.sv
// Self-checking bench for multi_mode_counter: directed scenarios then random
// traffic, all compared against an integer reference model.
module tb_multi_mode_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          direction;
  logic [1:0]    mode;
  logic [W-1:0]  limit;
  logic [W-1:0]  step;
  logic [PW-1:0] prescale;
  logic          clear;
  logic          load;
  logic          clearFlag;
  logic [W-1:0]  loadValue;
  logic [W-1:0]  counterValue;
  logic          terminalCount;
  logic          overflow;
  logic          countingUp;

  int assertCount = 0;
  int failCount   = 0;

  int mVal;
  int mPsc;
  bit mUp;
  bit mTc;
  bit mOvf;

  multi_mode_counter #(.WIDTH(W), .PWIDTH(PW)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .direction(direction),
    .mode(mode),
    .limit(limit),
    .step(step),
    .prescale(prescale),
    .clear(clear),
    .load(load),
    .clearFlag(clearFlag),
    .loadValue(loadValue),
    .counterValue(counterValue),
    .terminalCount(terminalCount),
    .overflow(overflow),
    .countingUp(countingUp)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic applyStimulus(input bit en, input bit dir, input logic [1:0] md,
                               input logic [W-1:0] lim, input logic [W-1:0] st,
                               input logic [PW-1:0] psc, input bit clr, input bit ld,
                               input bit cf, input logic [W-1:0] lv);
    enable    = en;
    direction = dir;
    mode      = md;
    limit     = lim;
    step      = st;
    prescale  = psc;
    clear     = clr;
    load      = ld;
    clearFlag = cf;
    loadValue = lv;
  endtask

  task automatic modelReset();
    mVal = 0;
    mPsc = 0;
    mUp  = 1'b1;
    mTc  = 1'b0;
    mOvf = 1'b0;
  endtask

  // Reference behaviour of one rising edge, straight from the counting rules.
  task automatic modelEdge();
    int v;
    int st;
    int lim;
    int maxv;
    int nv;
    bit tick;
    bit ev;
    bit up;
    bit nUp;
    v    = mVal;
    st   = int'(step);
    lim  = int'(limit);
    maxv = (1 << W) - 1;
    nv   = v;
    nUp  = mUp;
    ev   = 1'b0;
    tick = 1'b0;
    if (clear) begin
      modelReset();
      return;
    end
    if (load) begin
      mVal = (mode >= 2'd2 && int'(loadValue) > lim) ? lim : int'(loadValue);
      mPsc = 0;
      mUp  = direction;
      mTc  = 1'b0;
      if (clearFlag) mOvf = 1'b0;
      return;
    end
    if (enable) begin
      if (mPsc == int'(prescale)) tick = 1'b1;
      if (mPsc >= int'(prescale)) mPsc = 0;
      else mPsc = mPsc + 1;
    end
    if (tick && st != 0) begin
      up = (mode == 2'd3) ? mUp : direction;
      case (mode)
        2'd0: begin
          if (up) begin
            nv = v + st;
            if (nv > maxv) begin nv = nv - (maxv + 1); ev = 1'b1; end
          end else begin
            nv = v - st;
            if (nv < 0) begin nv = nv + (maxv + 1); ev = 1'b1; end
          end
        end
        2'd1: begin
          if (up) begin
            nv = v + st;
            if (nv > maxv) begin nv = maxv; ev = 1'b1; end
          end else begin
            nv = v - st;
            if (nv < 0) begin nv = 0; ev = 1'b1; end
          end
        end
        2'd2: begin
          if (up) begin
            nv = v + st;
            if (nv > lim) begin nv = 0; ev = 1'b1; end
          end else begin
            nv = v - st;
            if (st > v) begin nv = lim; ev = 1'b1; end
          end
        end
        default: begin
          if (up) begin
            nv = v + st;
            if (nv >= lim) begin nv = lim; ev = 1'b1; nUp = 1'b0; end
          end else begin
            nv = v - st;
            if (st >= v) begin nv = 0; ev = 1'b1; nUp = 1'b1; end
          end
        end
      endcase
    end
    mVal = nv;
    mUp  = nUp;
    mTc  = ev;
    if (ev) mOvf = 1'b1;
    else if (clearFlag) mOvf = 1'b0;
  endtask

  task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [W-1:0] eVal;
    logic         eCu;
    eVal = mVal[W-1:0];
    eCu  = (mode == 2'd3) ? mUp : direction;
    checkValue({tag, ".counterValue"}, counterValue, eVal);
    checkBit({tag, ".terminalCount"}, terminalCount, mTc);
    checkBit({tag, ".overflow"}, overflow, mOvf);
    checkBit({tag, ".countingUp"}, countingUp, eCu);
  endtask

  // One rising edge: model and DUT advance together, outputs compared 1 time unit later.
  task automatic runCycle(input string tag);
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput(tag);
    @(negedge clock);
  endtask

  initial begin
    bit          rEn;
    bit          rDir;
    logic [1:0]  rMode;
    logic [W-1:0] rLim;
    logic [W-1:0] rStep;
    logic [W-1:0] rLv;

    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    modelReset();
    #1;
    checkValue("reset.counterValue", counterValue, 8'h00);
    checkBit("reset.terminalCount", terminalCount, 1'b0);
    checkBit("reset.overflow", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Wrap through FF to 00.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd0, 8'd1, 4'd0, 1'b0, 1'b1, 1'b0, 8'hFE);
    runCycle("wrapLoad");
    load = 1'b0;
    runCycle("wrapFF");
    checkValue("wrapFF.value", counterValue, 8'hFF);
    runCycle("wrap00");
    checkValue("wrap00.value", counterValue, 8'h00);
    checkBit("wrap00.pulse", terminalCount, 1'b1);
    checkBit("wrap00.overflow", overflow, 1'b1);
    runCycle("wrapAfter");
    checkBit("wrapAfter.pulseGone", terminalCount, 1'b0);

    // Saturate down, re-pulse at the bound, then clearFlag.
    applyStimulus(1'b1, 1'b0, 2'd1, 8'd0, 8'd3, 4'd0, 1'b0, 1'b1, 1'b0, 8'd2);
    runCycle("satLoad");
    load = 1'b0;
    runCycle("satClamp");
    checkValue("satClamp.value", counterValue, 8'd0);
    checkBit("satClamp.pulse", terminalCount, 1'b1);
    runCycle("satRepulse");
    checkBit("satRepulse.pulse", terminalCount, 1'b1);
    enable    = 1'b0;
    clearFlag = 1'b1;
    runCycle("satClearFlag");
    checkBit("satClearFlag.overflow", overflow, 1'b0);

    // Modulo 9 with step 4 up, then down from 0.
    applyStimulus(1'b1, 1'b1, 2'd2, 8'd9, 8'd4, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    runCycle("modClear");
    clear = 1'b0;
    runCycle("mod4");
    runCycle("mod8");
    runCycle("mod0");
    checkValue("mod0.value", counterValue, 8'd0);
    checkBit("mod0.pulse", terminalCount, 1'b1);
    runCycle("mod4b");
    clear = 1'b1;
    runCycle("modClear2");
    clear     = 1'b0;
    direction = 1'b0;
    runCycle("modDown9");
    checkValue("modDown9.value", counterValue, 8'd9);
    checkBit("modDown9.pulse", terminalCount, 1'b1);

    // Ping-pong between 0 and 5 with step 2.
    applyStimulus(1'b1, 1'b0, 2'd3, 8'd5, 8'd2, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    runCycle("ppClear");
    clear = 1'b0;
    runCycle("pp2");
    runCycle("pp4");
    runCycle("pp5");
    checkValue("pp5.value", counterValue, 8'd5);
    checkBit("pp5.pulse", terminalCount, 1'b1);
    checkBit("pp5.countingUp", countingUp, 1'b0);
    runCycle("pp3");
    runCycle("pp1");
    runCycle("pp0");
    checkValue("pp0.value", counterValue, 8'd0);
    checkBit("pp0.countingUp", countingUp, 1'b1);

    // Prescale 3, with a two-cycle enable gap.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd0, 8'd1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    runCycle("psClear");
    clear = 1'b0;
    runCycle("ps1");
    runCycle("ps2");
    runCycle("ps3");
    checkValue("ps3.value", counterValue, 8'd0);
    runCycle("ps4");
    checkValue("ps4.value", counterValue, 8'd1);
    runCycle("ps5");
    enable = 1'b0;
    runCycle("psGap1");
    runCycle("psGap2");
    enable = 1'b1;
    for (int i = 0; i < 4; i++) runCycle("psResume");

    // Clear beats load and a wrapping tick in the same cycle.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd0, 8'd1, 4'd0, 1'b0, 1'b1, 1'b0, 8'hFF);
    runCycle("prioLoad");
    clear     = 1'b1;
    loadValue = 8'h55;
    runCycle("prioClear");
    checkValue("prioClear.value", counterValue, 8'd0);
    checkBit("prioClear.pulse", terminalCount, 1'b0);

    // Asynchronous reset in the middle of a cycle with pulse and flag set.
    applyStimulus(1'b1, 1'b1, 2'd1, 8'd0, 8'd1, 4'd0, 1'b0, 1'b1, 1'b0, 8'hFF);
    runCycle("rstLoad");
    load = 1'b0;
    runCycle("rstSat");
    direction = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkValue("asyncReset.counterValue", counterValue, 8'd0);
    checkBit("asyncReset.terminalCount", terminalCount, 1'b0);
    checkBit("asyncReset.overflow", overflow, 1'b0);
    checkBit("asyncReset.countingUp", countingUp, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Random traffic against the model.
    rMode = 2'd0;
    rLim  = 8'd10;
    for (int i = 0; i < 500; i++) begin
      rEn  = ($urandom_range(0, 3) != 0);
      rDir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) rMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        rLim = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
      rStep = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      rLv   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      applyStimulus(rEn, rDir, rMode, rLim, rStep, 4'($urandom_range(0, 3)),
                    ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0), rLv);
      runCycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
